// File: rtl/atmega_cap_pkg.sv
// atmega_pwm_capture shared definitions: prescaler selects,
// register bit positions, capture FSM states, tick selection.
package atmega_cap_pkg;

  localparam logic [2:0] CS_STOP    = 3'd0;
  localparam logic [2:0] CS_CLK1    = 3'd1;
  localparam logic [2:0] CS_CLK8    = 3'd2;
  localparam logic [2:0] CS_CLK64   = 3'd3;
  localparam logic [2:0] CS_CLK256  = 3'd4;
  localparam logic [2:0] CS_CLK1024 = 3'd5;

  localparam int CTRL_NC  = 3;
  localparam int CTRL_INV = 4;
  localparam int CTRL_EN  = 7;

  localparam int STAT_CAPF = 0;
  localparam int STAT_OVF  = 1;
  localparam int STAT_BUSY = 2;

  localparam int MSK_CAPIE = 0;
  localparam int MSK_OVFIE = 1;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cap_state_t;

  function automatic logic cs_valid(
    input logic [2:0] cs
  );
    return (cs >= CS_CLK1) && (cs <= CS_CLK1024);
  endfunction

  function automatic logic sel_tick(
    input logic [2:0] cs,
    input logic       c8,
    input logic       c64,
    input logic       c256,
    input logic       c1024
  );
    logic t;
    t = 1'b0;
    case (cs)
      CS_CLK1:    t = 1'b1;
      CS_CLK8:    t = c8;
      CS_CLK64:   t = c64;
      CS_CLK256:  t = c256;
      CS_CLK1024: t = c1024;
      default:    t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/cap_input_cond.sv
// Input conditioning: 2-flop sync, optional invert, 4-sample filter.
// Ports: clk/rst, icp raw input, inv/nc controls; level, rise, fall out.
module cap_input_cond
  import atmega_cap_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic icp,
  input  logic inv,
  input  logic nc,
  output logic level,
  output logic rise,
  output logic fall
);

  logic       s1;
  logic       s2;
  logic       smp;
  logic [2:0] hist;
  logic       stable;
  logic       nxt;

  assign smp = s2 ^ inv;

  // With the filter on, the level moves only once the current
  // sample and the three before it all agree.
  assign stable = nc ? (hist == {3{smp}}) : 1'b1;
  assign nxt    = stable ? smp : level;

  // Strobes fire in the cycle before level updates so the
  // FSM registers the edge on the same clock as level.
  assign rise = nxt & ~level;
  assign fall = ~nxt & level;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      hist  <= '0;
      level <= 1'b0;
    end else begin
      s1    <= icp;
      s2    <= s1;
      hist  <= {hist[1:0], smp};
      level <= nxt;
    end
  end

endmodule

// File: rtl/atmega_pwm_capture.sv
// Pulse-width/period capture with AVR-style TEMP 16-bit reads.
// Ports: clk/rst, prescaler strobes, 8-bit bus, icp, two int handshakes.
module atmega_pwm_capture
  import atmega_cap_pkg::*;
#(
  parameter int BUS_ADDR_DATA_LEN = 8,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] CTRL_ADDR  = 'hA0,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] STAT_ADDR  = 'hA1,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] MSK_ADDR   = 'hA2,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] PERL_ADDR  = 'hA4,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] PERH_ADDR  = 'hA5,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] HIGHL_ADDR = 'hA6,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] HIGHH_ADDR = 'hA7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk8,
  input  logic                         clk64,
  input  logic                         clk256,
  input  logic                         clk1024,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr_dat,
  input  logic                         wr_dat,
  input  logic                         rd_dat,
  input  logic [7:0]                   bus_dat_in,
  output logic [7:0]                   bus_dat_out,
  input  logic                         icp,
  output logic                         cap_int,
  input  logic                         cap_int_rst,
  output logic                         ovf_int,
  input  logic                         ovf_int_rst
);

  logic [7:0]  ctrl;
  logic [7:0]  msk;
  logic [7:0]  temp;
  logic [15:0] cnt;
  logic [15:0] shadow;
  logic [15:0] per;
  logic [15:0] highr;
  logic        capf;
  logic        ovff;
  cap_state_t  state;

  logic        level;
  logic        rise;
  logic        fall;
  logic        unused_level;

  logic        sel_ctrl;
  logic        sel_stat;
  logic        sel_msk;
  logic        sel_perl;
  logic        sel_perh;
  logic        sel_highl;
  logic        sel_highh;
  logic        ctrl_wr;
  logic        stat_wr;
  logic        run;
  logic        tick;
  logic        busy;
  logic        ovf_hit;
  logic [15:0] cnt_inc;
  logic [7:0]  stat;

  cap_input_cond u_cond (
    .clk   (clk),
    .rst   (rst),
    .icp   (icp),
    .inv   (ctrl[CTRL_INV]),
    .nc    (ctrl[CTRL_NC]),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  // FSM is edge driven; the level itself is not needed here.
  assign unused_level = level;

  assign sel_ctrl  = (addr_dat == CTRL_ADDR);
  assign sel_stat  = (addr_dat == STAT_ADDR);
  assign sel_msk   = (addr_dat == MSK_ADDR);
  assign sel_perl  = (addr_dat == PERL_ADDR);
  assign sel_perh  = (addr_dat == PERH_ADDR);
  assign sel_highl = (addr_dat == HIGHL_ADDR);
  assign sel_highh = (addr_dat == HIGHH_ADDR);

  assign ctrl_wr = wr_dat & sel_ctrl;
  assign stat_wr = wr_dat & sel_stat;

  assign run  = ctrl[CTRL_EN] & cs_valid(ctrl[2:0]);
  assign tick = sel_tick(ctrl[2:0], clk8, clk64,
                         clk256, clk1024);
  assign busy = (state != WAIT);

  // An edge arriving together with a tick is counted, so the
  // captured value is the tick count over the whole interval.
  assign cnt_inc = cnt + {15'd0, tick};
  assign ovf_hit = tick & (cnt == 16'hFFFF);

  assign stat = {5'd0, busy, ovff, capf};

  always_comb begin
    bus_dat_out = '0;
    if (rd_dat) begin
      unique case (1'b1)
        sel_ctrl:  bus_dat_out = ctrl;
        sel_stat:  bus_dat_out = stat;
        sel_msk:   bus_dat_out = msk;
        sel_perl:  bus_dat_out = per[7:0];
        sel_perh:  bus_dat_out = temp;
        sel_highl: bus_dat_out = highr[7:0];
        sel_highh: bus_dat_out = temp;
        default:   bus_dat_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl    <= '0;
      msk     <= '0;
      temp    <= '0;
      cnt     <= '0;
      shadow  <= '0;
      per     <= '0;
      highr   <= '0;
      capf    <= 1'b0;
      ovff    <= 1'b0;
      cap_int <= 1'b0;
      ovf_int <= 1'b0;
      state   <= WAIT;
    end else begin
      cap_int <= capf & msk[MSK_CAPIE];
      ovf_int <= ovff & msk[MSK_OVFIE];

      if (ctrl_wr)
        ctrl <= bus_dat_in;
      if (wr_dat & sel_msk)
        msk <= bus_dat_in;

      // TEMP takes the pre-capture high byte on an L read.
      if (rd_dat & sel_perl)
        temp <= per[15:8];
      else if (rd_dat & sel_highl)
        temp <= highr[15:8];

      // Clears first; the FSM sets below override them.
      if (cap_int_rst | (stat_wr & bus_dat_in[STAT_CAPF]))
        capf <= 1'b0;
      if (ovf_int_rst | (stat_wr & bus_dat_in[STAT_OVF]))
        ovff <= 1'b0;

      if (!run || ctrl_wr) begin
        state <= WAIT;
        cnt   <= '0;
      end else if (busy && ovf_hit) begin
        ovff  <= 1'b1;
        cnt   <= '0;
        state <= WAIT;
      end else begin
        unique case (state)
          WAIT: begin
            if (rise) begin
              cnt   <= '0;
              state <= HIGH;
            end
          end
          HIGH: begin
            cnt <= cnt_inc;
            if (fall) begin
              shadow <= cnt_inc;
              state  <= LOW;
            end
          end
          LOW: begin
            if (rise) begin
              per   <= cnt_inc;
              highr <= shadow;
              capf  <= 1'b1;
              cnt   <= '0;
              state <= HIGH;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: state <= WAIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_atmega_pwm_capture.sv
// Scoreboarded bench for atmega_pwm_capture.
// Drives icp waveforms and bus accesses, checks captured registers.
module tb_atmega_pwm_capture;

  localparam logic [7:0] A_CTRL  = 8'hA0;
  localparam logic [7:0] A_STAT  = 8'hA1;
  localparam logic [7:0] A_MSK   = 8'hA2;
  localparam logic [7:0] A_PERL  = 8'hA4;
  localparam logic [7:0] A_PERH  = 8'hA5;
  localparam logic [7:0] A_HIGHL = 8'hA6;
  localparam logic [7:0] A_HIGHH = 8'hA7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk8 = 1'b0;
  logic       clk64 = 1'b0;
  logic       clk256 = 1'b0;
  logic       clk1024 = 1'b0;
  logic [7:0] addr_dat = '0;
  logic       wr_dat = 1'b0;
  logic       rd_dat = 1'b0;
  logic [7:0] bus_dat_in = '0;
  logic [7:0] bus_dat_out;
  logic       icp = 1'b0;
  logic       cap_int;
  logic       cap_int_rst = 1'b0;
  logic       ovf_int;
  logic       ovf_int_rst = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int unsigned div = 0;

  typedef struct {
    string      tag;
    logic [7:0] addr;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];

  atmega_pwm_capture dut (
    .clk         (clk),
    .rst         (rst),
    .clk8        (clk8),
    .clk64       (clk64),
    .clk256      (clk256),
    .clk1024     (clk1024),
    .addr_dat    (addr_dat),
    .wr_dat      (wr_dat),
    .rd_dat      (rd_dat),
    .bus_dat_in  (bus_dat_in),
    .bus_dat_out (bus_dat_out),
    .icp         (icp),
    .cap_int     (cap_int),
    .cap_int_rst (cap_int_rst),
    .ovf_int     (ovf_int),
    .ovf_int_rst (ovf_int_rst)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    div     = div + 1;
    clk8    = (div % 8) == 0;
    clk64   = (div % 64) == 0;
    clk256  = (div % 256) == 0;
    clk1024 = (div % 1024) == 0;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [7:0] a,
                        input logic [7:0] d);
    @(negedge clk);
    addr_dat   = a;
    bus_dat_in = d;
    wr_dat     = 1'b1;
    @(negedge clk);
    wr_dat     = 1'b0;
  endtask

  task automatic bus_rd(input  logic [7:0] a,
                        output logic [7:0] d);
    @(negedge clk);
    addr_dat = a;
    rd_dat   = 1'b1;
    #1 d = bus_dat_out;
    @(negedge clk);
    rd_dat   = 1'b0;
  endtask

  task automatic push(input string tag,
                      input logic [7:0] a,
                      input logic [7:0] v);
    exp_t e;
    e.tag  = tag;
    e.addr = a;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic push16(input string tag,
                        input logic [7:0] la,
                        input logic [15:0] v);
    push({tag, "_l"}, la, v[7:0]);
    push({tag, "_h"}, la + 8'd1, v[15:8]);
  endtask

  task automatic drain();
    exp_t       e;
    logic [7:0] got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus_rd(e.addr, got);
      chk(e.tag, {24'd0, got}, {24'd0, e.val});
    end
  endtask

  task automatic sq(input int h, input int l, input int n);
    repeat (n) begin
      icp = 1'b1;
      hold(h);
      icp = 1'b0;
      hold(l);
    end
  endtask

  logic [7:0] d;

  initial begin
    hold(3);
    rst = 1'b0;
    #1;
    chk("rst_bus_idle", {24'd0, bus_dat_out}, 0);
    chk("rst_cap_int", {31'd0, cap_int}, 0);
    chk("rst_ovf_int", {31'd0, ovf_int}, 0);
    push("rst_ctrl", A_CTRL, 8'h00);
    push("rst_stat", A_STAT, 8'h00);
    push("rst_msk", A_MSK, 8'h00);
    push16("rst_per", A_PERL, 16'h0000);
    push16("rst_high", A_HIGHL, 16'h0000);
    drain();

    // basic capture, CS=1
    hold(5);
    bus_wr(A_MSK, 8'h01);
    bus_wr(A_CTRL, 8'h81);
    hold(5);
    sq(40, 60, 2);
    icp = 1'b1;
    hold(8);
    push16("basic_per", A_PERL, 16'h0064);
    push16("basic_high", A_HIGHL, 16'h0028);
    push("basic_stat", A_STAT, 8'h05);
    drain();
    chk("basic_cap_int", {31'd0, cap_int}, 1);
    @(negedge clk);
    cap_int_rst = 1'b1;
    @(negedge clk);
    cap_int_rst = 1'b0;
    hold(2);
    chk("basic_cap_ack", {31'd0, cap_int}, 0);
    push("basic_stat_ack", A_STAT, 8'h04);
    drain();

    // prescaled capture, CS=2
    icp = 1'b0;
    hold(10);
    bus_wr(A_STAT, 8'h03);
    bus_wr(A_CTRL, 8'h82);
    hold(5);
    sq(800, 1200, 2);
    icp = 1'b1;
    hold(20);
    bus_wr(A_PERL, 8'h55);
    bus_wr(A_PERH, 8'h55);
    push16("pre_per", A_PERL, 16'h00FA);
    push16("pre_high", A_HIGHL, 16'h0064);
    push("pre_stat", A_STAT, 8'h05);
    drain();

    // overflow
    icp = 1'b0;
    hold(10);
    bus_wr(A_STAT, 8'h03);
    bus_wr(A_MSK, 8'h03);
    bus_wr(A_CTRL, 8'h81);
    hold(5);
    icp = 1'b1;
    hold(70000);
    push("ovf_stat", A_STAT, 8'h02);
    push16("ovf_per", A_PERL, 16'h00FA);
    push16("ovf_high", A_HIGHL, 16'h0064);
    drain();
    chk("ovf_int", {31'd0, ovf_int}, 1);
    chk("ovf_no_cap_int", {31'd0, cap_int}, 0);
    @(negedge clk);
    ovf_int_rst = 1'b1;
    @(negedge clk);
    ovf_int_rst = 1'b0;
    hold(2);
    chk("ovf_ack", {31'd0, ovf_int}, 0);

    // noise canceller
    icp = 1'b0;
    hold(10);
    bus_wr(A_STAT, 8'h03);
    bus_wr(A_CTRL, 8'h89);
    hold(10);
    sq(2, 20, 3);
    push("nc_glitch_stat", A_STAT, 8'h00);
    drain();
    sq(50, 50, 2);
    icp = 1'b1;
    hold(12);
    push16("nc_per", A_PERL, 16'h0064);
    push16("nc_high", A_HIGHL, 16'h0032);
    push("nc_stat", A_STAT, 8'h05);
    drain();

    // atomic TEMP read across a capture
    icp = 1'b0;
    hold(10);
    bus_wr(A_STAT, 8'h03);
    bus_wr(A_CTRL, 8'h81);
    hold(5);
    sq(40, 60, 1);
    icp = 1'b1;
    hold(10);
    bus_rd(A_PERL, d);
    chk("atom_perl", {24'd0, d}, 32'h64);
    hold(88);
    icp = 1'b0;
    hold(200);
    icp = 1'b1;
    hold(8);
    bus_rd(A_PERH, d);
    chk("atom_perh_old", {24'd0, d}, 32'h00);
    push16("atom_per", A_PERL, 16'h012C);
    push16("atom_high", A_HIGHL, 16'h0064);
    drain();

    // capture and write-1-clear on the same edge
    icp = 1'b0;
    hold(30);
    bus_wr(A_STAT, 8'h01);
    hold(20);
    push("same_pre", A_STAT, 8'h04);
    drain();
    icp = 1'b1;
    hold(2);
    addr_dat   = A_STAT;
    bus_dat_in = 8'h01;
    wr_dat     = 1'b1;
    @(negedge clk);
    wr_dat     = 1'b0;
    hold(5);
    push("same_set_wins", A_STAT, 8'h05);
    drain();

    // reset while in LOW
    icp = 1'b0;
    hold(20);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_cap_int", {31'd0, cap_int}, 0);
    chk("mrst_ovf_int", {31'd0, ovf_int}, 0);
    push("mrst_ctrl", A_CTRL, 8'h00);
    push("mrst_stat", A_STAT, 8'h00);
    push("mrst_msk", A_MSK, 8'h00);
    push16("mrst_per", A_PERL, 16'h0000);
    push16("mrst_high", A_HIGHL, 16'h0000);
    drain();
    bus_wr(A_MSK, 8'h01);
    bus_wr(A_CTRL, 8'h81);
    hold(5);
    icp = 1'b1;
    hold(10);
    push("mrst_one_edge", A_STAT, 8'h04);
    drain();
    chk("mrst_no_cap_int", {31'd0, cap_int}, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
